// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
// The per-stage payload structs set the DATA_W of each pipe_skid_reg instance.
package mips_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pcNext;
        logic [31:0] instruction;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pcNext;
        logic [31:0] readData1;
        logic [31:0] readData2;
        logic [31:0] signImm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [4:0]  writeReg;
        logic [4:0]  ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] readData;
        logic [31:0] aluResult;
        logic [4:0]  writeReg;
        logic [1:0]  ctrl;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic [1:0] occCount(input logic mainValid, input logic skidValid);
        return {1'b0, mainValid} + {1'b0, skidValid};
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with an optional skid slot that keeps i_ready
// registered while still sustaining one transfer per cycle under backpressure.
module pipe_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int                 DATA_W      = 64,
    parameter bit                 SKID_EN     = 1'b1,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);

    logic              r_mainValid;
    logic [DATA_W-1:0] r_mainData;
    logic              w_skidValid;
    logic [DATA_W-1:0] w_skidData;
    logic              w_inFire;
    logic              w_mainFree;

    assign w_inFire   = i_valid & i_ready;
    assign w_mainFree = ~r_mainValid | o_ready;

    // The skid entry is older than any incoming word, so it always refills main first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mainValid <= 1'b0;
            r_mainData  <= BUBBLE_DATA;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_mainData  <= BUBBLE_DATA;
        end else if (w_mainFree) begin
            if (w_skidValid) begin
                r_mainValid <= 1'b1;
                r_mainData  <= w_skidData;
            end else if (w_inFire) begin
                r_mainValid <= 1'b1;
                r_mainData  <= i_data;
            end else begin
                r_mainValid <= 1'b0;
            end
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic              r_skidValid;
            logic [DATA_W-1:0] r_skidData;
            logic              w_skidLoad;

            // Park the new word when main is stalled or is busy draining the skid.
            assign w_skidLoad = w_inFire & (r_skidValid | ~w_mainFree);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_skidValid <= 1'b0;
                    r_skidData  <= BUBBLE_DATA;
                end else if (flush) begin
                    r_skidValid <= 1'b0;
                end else begin
                    r_skidValid <= w_skidLoad | (r_skidValid & ~w_mainFree);
                    if (w_skidLoad) begin
                        r_skidData <= i_data;
                    end
                end
            end

            assign w_skidValid = r_skidValid;
            assign w_skidData  = r_skidData;
            assign i_ready     = ~r_skidValid;
        end else begin : g_noSkid
            assign w_skidValid = 1'b0;
            assign w_skidData  = BUBBLE_DATA;
            assign i_ready     = w_mainFree;
        end
    endgenerate

    assign o_valid = r_mainValid;
    assign o_data  = r_mainData;
    assign o_occ   = occCount(r_mainValid, w_skidValid);

endmodule
